// File: rtl/weighted_symbol_sampler.sv
// weighted_symbol_sampler: streams symbols drawn from a weighted categorical distribution via a rejection-sampled Galois LFSR
module weighted_symbol_sampler #(
    parameter int NUM_CAT = 4,
    parameter int PROB_W = 10,
    parameter int SCALE = 1000,
    parameter int LFSR_W = 32,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 32'h80200003,
    parameter logic [LFSR_W-1:0] SEED = 32'h1,
    parameter int LEN_W = 16,
    localparam int SYM_W = $clog2(NUM_CAT),
    localparam int RAND_W = $clog2(SCALE),
    localparam int SUM_W = PROB_W + $clog2(NUM_CAT)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      seed_load,
    input  logic [LFSR_W-1:0]         seed,
    input  logic [NUM_CAT*PROB_W-1:0] probs,
    input  logic [LEN_W-1:0]          seq_len,
    input  logic                      start,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SYM_W-1:0]          out_sym,
    output logic                      out_last,
    output logic                      done,
    output logic                      err_sum
);
    localparam int CMP_W = SUM_W > RAND_W ? SUM_W : RAND_W;
    typedef enum logic [1:0] {IDLE, CHECK, DRAW, OUT} state_t;
    state_t state, state_d;
    logic [LFSR_W-1:0] lfsr, lfsr_step;
    logic [NUM_CAT*PROB_W-1:0] probs_q;
    logic [LEN_W-1:0] len, count;
    logic [NUM_CAT-1:0][SUM_W-1:0] cum;
    logic [SUM_W-1:0] acc, total;
    logic [CMP_W-1:0] r;
    logic [SYM_W-1:0] pick;
    logic accept, bad;
    assign lfsr_step = lfsr[0] ? (lfsr >> 1) ^ LFSR_TAPS : lfsr >> 1;
    assign total = cum[NUM_CAT-1];
    assign r = CMP_W'(lfsr[RAND_W-1:0]);
    assign accept = r < CMP_W'(total);
    assign bad = total == '0 || 32'(total) > SCALE;
    assign busy = state != IDLE;
    always_comb begin
        acc = '0;
        cum = '0;
        for (int k = 0; k < NUM_CAT; k++) begin
            acc = acc + SUM_W'(probs_q[k*PROB_W +: PROB_W]);
            cum[k] = acc;
        end
    end
    always_comb begin
        pick = '0;
        for (int k = NUM_CAT - 1; k >= 0; k--)
            if (r < CMP_W'(cum[k])) pick = SYM_W'(k);
    end
    always_comb begin
        state_d = state;
        case (state)
            IDLE:  state_d = start && !seed_load ? CHECK : IDLE;
            CHECK: state_d = bad || len == '0 ? IDLE : DRAW;
            DRAW:  state_d = accept ? OUT : DRAW;
            OUT:   state_d = out_ready ? (out_last ? IDLE : DRAW) : OUT;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_d;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= SEED;
            count <= '0;
            len <= '0;
            probs_q <= '0;
            out_valid <= 1'b0;
            out_sym <= '0;
            out_last <= 1'b0;
            done <= 1'b0;
            err_sum <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (seed_load) begin
                        lfsr <= seed == '0 ? LFSR_W'(1) : seed;
                    end else if (start) begin
                        probs_q <= probs;
                        len <= seq_len;
                        count <= '0;
                        err_sum <= 1'b0;
                    end
                end
                CHECK: begin
                    done <= bad || len == '0;
                    err_sum <= bad;
                end
                DRAW: begin
                    lfsr <= lfsr_step;
                    if (accept) begin
                        out_valid <= 1'b1;
                        out_sym <= pick;
                        out_last <= count == len - LEN_W'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        count <= count + LEN_W'(1);
                        if (out_last) begin
                            done <= 1'b1;
                            out_last <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
